// File: rtl/systolic_feeder.sv
// Systolic array feeder: accepts one k-slice per beat (N activations, N weights),
// skews the rows/columns diagonally and sequences clear, feed, flush and done
// for an NxN output-stationary sign-magnitude MAC array.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic [N*DW-1:0] in_weight,
    input  logic            in_last,
    output logic [N*DW-1:0] data_out,
    output logic [N*DW-1:0] weight_out,
    output logic            en,
    output logic            arr_clr_n,
    output logic            busy,
    output logic            done,
    output logic [15:0]     beats
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Zero-padding cycles needed for the last element to reach PE(N-1,N-1).
    localparam int FLUSH_LEN = 2 * N - 2;
    localparam int CW        = 6;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   flushCnt_q, flushCnt_d;
    logic [15:0]     beats_q, beats_d;
    logic            en_q;
    logic            clrN_q;
    logic            done_q;

    logic            accept;
    logic            advance;
    logic            flushEnd;
    logic [N*DW-1:0] rowIn;
    logic [N*DW-1:0] colIn;

    assign accept   = (state_q == FEED) && in_valid;
    assign advance  = accept || (state_q == FLUSH);
    assign flushEnd = (flushCnt_q == CW'(FLUSH_LEN - 1));

    // Only FEED injects real data; FLUSH pushes zero elements whose products are zero.
    assign rowIn = (state_q == FEED) ? in_data   : '0;
    assign colIn = (state_q == FEED) ? in_weight : '0;

    // Tile sequencer next-state, flush counter and saturating beat counter.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        beats_d    = beats_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    beats_d = '0;
                end
            end
            CLR: begin
                state_d = FEED;
            end
            FEED: begin
                if (accept) begin
                    if (beats_q != 16'hFFFF) begin
                        beats_d = beats_q + 16'd1;
                    end
                    if (in_last) begin
                        state_d    = (N == 1) ? DONE : FLUSH;
                        flushCnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                flushCnt_d = flushCnt_q + CW'(1);
                if (flushEnd) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers; done trails DONE by one cycle so the array's final accumulate has landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            flushCnt_q <= '0;
            beats_q    <= '0;
            en_q       <= 1'b0;
            clrN_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            beats_q    <= beats_d;
            en_q       <= advance;
            clrN_q     <= (state_d != CLR);
            done_q     <= (state_q == DONE);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : gRow
            logic [DW-1:0] pipe_q [0:gi];

            // Row gi delay line of gi+1 stages, shifting only on advance so stalls freeze it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k <= gi; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else if (advance) begin
                    pipe_q[0] <= rowIn[gi*DW +: DW];
                    for (int k = 1; k <= gi; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign data_out[gi*DW +: DW] = pipe_q[gi];
        end

        for (gi = 0; gi < N; gi++) begin : gCol
            logic [DW-1:0] pipe_q [0:gi];

            // Column gi delay line of gi+1 stages, shifting only on advance so stalls freeze it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k <= gi; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else if (advance) begin
                    pipe_q[0] <= colIn[gi*DW +: DW];
                    for (int k = 1; k <= gi; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign weight_out[gi*DW +: DW] = pipe_q[gi];
        end
    endgenerate

    assign in_ready  = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign en        = en_q;
    assign arr_clr_n = clrN_q;
    assign done      = done_q;
    assign beats     = beats_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed testbench for systolic_feeder: an N=4 instance driving a behavioural
// sign-magnitude PE array, plus an N=1 instance for the degenerate build.
module tb_systolic_feeder;

    logic        clk;
    logic        rst;

    logic        start;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic [31:0] inWeight;
    logic        inLast;
    logic [31:0] dataOut;
    logic [31:0] weightOut;
    logic        en;
    logic        arrClrN;
    logic        busy;
    logic        done;
    logic [15:0] beats;

    logic        s1Start;
    logic        s1Valid;
    logic        s1Ready;
    logic [7:0]  s1Data;
    logic [7:0]  s1Weight;
    logic        s1Last;
    logic [7:0]  s1DataOut;
    logic [7:0]  s1WeightOut;
    logic        s1En;
    logic        s1ClrN;
    logic        s1Busy;
    logic        s1Done;
    logic [15:0] s1Beats;

    int checks = 0;
    int errors = 0;

    // Stimulus matrices: activation row i / beat k, weight beat k / column j.
    logic [7:0] aMat [4][8];
    logic [7:0] wMat [8][4];

    // Downstream array model state.
    int         mSum [4][4];
    logic [7:0] mA   [4][4];
    logic [7:0] mW   [4][4];

    // Per-cycle traces of one tile, cycle 0 being the sample after the start edge.
    logic        enTr     [64];
    logic        clrTr    [64];
    logic        readyTr  [64];
    logic        stallTr  [64];
    logic [31:0] dataTr   [64];
    logic [31:0] weightTr [64];
    int enCount, firstEn, lastEn, doneCyc, doneCount;

    int idleBad, stallSeen, freezeBad;
    int n1k, n1En, n1Done;
    logic [7:0] n1Data0, n1Weight0;
    logic [7:0] n1Vals [3];

    systolic_feeder #(.N(4), .DW(8)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_data    (inData),
        .in_weight  (inWeight),
        .in_last    (inLast),
        .data_out   (dataOut),
        .weight_out (weightOut),
        .en         (en),
        .arr_clr_n  (arrClrN),
        .busy       (busy),
        .done       (done),
        .beats      (beats)
    );

    systolic_feeder #(.N(1), .DW(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (s1Start),
        .in_valid   (s1Valid),
        .in_ready   (s1Ready),
        .in_data    (s1Data),
        .in_weight  (s1Weight),
        .in_last    (s1Last),
        .data_out   (s1DataOut),
        .weight_out (s1WeightOut),
        .en         (s1En),
        .arr_clr_n  (s1ClrN),
        .busy       (s1Busy),
        .done       (s1Done),
        .beats      (s1Beats)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int smVal(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [7:0] aAt(input int i, input int j);
        if (j == 0) return dataOut[i*8 +: 8];
        return mA[i][j-1];
    endfunction

    function automatic logic [7:0] wAt(input int i, input int j);
        if (i == 0) return weightOut[j*8 +: 8];
        return mW[i-1][j];
    endfunction

    function automatic int refSum(input int i, input int j, input int K);
        int s;
        s = 0;
        for (int k = 0; k < K; k++) s += smVal(aMat[i][k]) * smVal(wMat[k][j]);
        return s;
    endfunction

    // Behavioural output-stationary PE array fed by the feeder's edges.
    always @(posedge clk) begin
        if (!arrClrN) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mSum[i][j] <= 0;
                    mA[i][j]   <= 8'h00;
                    mW[i][j]   <= 8'h00;
                end
            end
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mSum[i][j] <= mSum[i][j] + smVal(aAt(i, j)) * smVal(wAt(i, j));
                    mA[i][j]   <= aAt(i, j);
                    mW[i][j]   <= wAt(i, j);
                end
            end
        end
    end

    // Single comparison point: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Compare all 16 model sums against the reference matmul.
    task automatic checkSums(input string tag, input int K);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                checkOutput($sformatf("%s_sum%0d%0d", tag, i, j), mSum[i][j], refSum(i, j, K));
            end
        end
    endtask

    // Directed mixed-sign fill; some entries land on negative zero on purpose.
    task automatic fillPattern(input int seed);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                aMat[i][k] = 8'((((i + k + seed) % 3) == 0 ? 128 : 0) + ((i * 5 + k * 3 + seed) % 13));
                wMat[k][i] = 8'((((i + 2 * k + seed) % 2) == 0 ? 128 : 0) + ((i * 7 + k + 2 * seed) % 11));
            end
        end
    endtask

    // Runs one tile on the N=4 instance and records per-cycle traces.
    // Outside FEED the bench still offers junk beats, which must never be taken.
    task automatic applyStimulus(input int K, input int stallBeat, input int stallLen,
                                 input bit holdStart, input int abortAt);
        int  cyc, k, stalled;
        bit  finished;
        for (int c = 0; c < 64; c++) begin
            enTr[c] = 1'b0; clrTr[c] = 1'b1; readyTr[c] = 1'b0; stallTr[c] = 1'b0;
            dataTr[c] = '0; weightTr[c] = '0;
        end
        enCount = 0; firstEn = -1; lastEn = -1; doneCyc = -1; doneCount = 0;
        start = 1'b1; inValid = 1'b0; inLast = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; k = 0; stalled = 0; finished = 1'b0;
        while (!finished && cyc < 64) begin
            enTr[cyc]     = en;
            clrTr[cyc]    = arrClrN;
            readyTr[cyc]  = inReady;
            dataTr[cyc]   = dataOut;
            weightTr[cyc] = weightOut;
            if (en) begin
                enCount++;
                if (firstEn < 0) firstEn = cyc;
                lastEn = cyc;
            end
            if (done) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (cyc == abortAt) begin
                finished = 1'b1;
            end else if (doneCyc >= 0 && cyc > doneCyc + 1) begin
                finished = 1'b1;
            end else begin
                start = holdStart && inReady;
                if (inReady && k < K) begin
                    if (k == stallBeat && stalled < stallLen) begin
                        inValid  = 1'b0;
                        inData   = 32'hDEADBEEF;
                        inWeight = 32'hCAFEF00D;
                        inLast   = 1'b1;
                        stalled++;
                        if (cyc + 1 < 64) stallTr[cyc+1] = 1'b1;
                    end else begin
                        inValid = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            inData[i*8 +: 8]   = aMat[i][k];
                            inWeight[i*8 +: 8] = wMat[k][i];
                        end
                        inLast = (k == K - 1);
                        k++;
                    end
                end else begin
                    inValid  = 1'b1;
                    inData   = 32'hA5A5A5A5;
                    inWeight = 32'h5A5A5A5A;
                    inLast   = 1'b1;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("tileCompleted", finished, 1);
        start = 1'b0; inValid = 1'b0; inLast = 1'b0;
    endtask

    // Directed sequence: reset, nominal tile, stall, K=1, reset mid-flush, N=1 build.
    initial begin
        rst = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        inData = '0; inWeight = '0;
        s1Start = 1'b0; s1Valid = 1'b0; s1Last = 1'b0; s1Data = '0; s1Weight = '0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_en", en, 0);
        checkOutput("rst_inReady", inReady, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_clrN", arrClrN, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_beats", beats, 0);
        checkOutput("rst_dataOut", dataOut, 0);
        checkOutput("rst_weightOut", weightOut, 0);
        rst = 1'b0;

        // Idle with junk offered on the stream and no start.
        inValid = 1'b1; inData = 32'h12345678; inWeight = 32'h9ABCDEF0; inLast = 1'b1;
        idleBad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (en || inReady || busy || !arrClrN || done || dataOut != 0 || weightOut != 0 || beats != 0)
                idleBad++;
        end
        checkOutput("idle20", idleBad, 0);
        inValid = 1'b0; inLast = 1'b0;

        $display("[TB] single tile K=3");
        fillPattern(1);
        applyStimulus(3, -1, 0, 1'b0, -1);
        checkOutput("t1_clrLow", clrTr[0], 0);
        checkOutput("t1_clrHigh", clrTr[1], 1);
        checkOutput("t1_readyCLR", readyTr[0], 0);
        checkOutput("t1_readyFEED", readyTr[1], 1);
        checkOutput("t1_firstEn", firstEn, 2);
        checkOutput("t1_lastEn", lastEn, 10);
        checkOutput("t1_enCount", enCount, 9);
        checkOutput("t1_doneCyc", doneCyc, 11);
        checkOutput("t1_doneCount", doneCount, 1);
        checkOutput("t1_row0", dataTr[2][7:0], aMat[0][0]);
        checkOutput("t1_row3Early", dataTr[4][31:24], 0);
        checkOutput("t1_row3", dataTr[5][31:24], aMat[3][0]);
        checkOutput("t1_col3", weightTr[5][31:24], wMat[0][3]);
        checkOutput("t1_beats", beats, 3);
        checkOutput("t1_busyAfter", busy, 0);
        checkSums("t1", 3);

        $display("[TB] stalled tile K=3 with start held in FEED");
        applyStimulus(3, 1, 5, 1'b1, -1);
        stallSeen = 0; freezeBad = 0;
        for (int c = 1; c < 64; c++) begin
            if (stallTr[c]) begin
                stallSeen++;
                if (enTr[c] !== 1'b0 || dataTr[c] !== dataTr[c-1] || weightTr[c] !== weightTr[c-1])
                    freezeBad++;
            end
        end
        checkOutput("t2_stallSeen", stallSeen, 5);
        checkOutput("t2_freeze", freezeBad, 0);
        checkOutput("t2_enCount", enCount, 9);
        checkOutput("t2_firstEn", firstEn, 2);
        checkOutput("t2_lastEn", lastEn, 15);
        checkOutput("t2_doneCyc", doneCyc, 16);
        checkOutput("t2_beats", beats, 3);
        checkSums("t2", 3);

        $display("[TB] K=1 tile");
        aMat[0][0] = 8'h85; aMat[1][0] = 8'h80; aMat[2][0] = 8'h02; aMat[3][0] = 8'h87;
        wMat[0][0] = 8'h03; wMat[0][1] = 8'h84; wMat[0][2] = 8'h81; wMat[0][3] = 8'h06;
        applyStimulus(1, -1, 0, 1'b0, -1);
        checkOutput("t3_firstEn", firstEn, 2);
        checkOutput("t3_lastEn", lastEn, 8);
        checkOutput("t3_enCount", enCount, 7);
        checkOutput("t3_doneCyc", doneCyc, 9);
        checkOutput("t3_beats", beats, 1);
        checkOutput("t3_row1Early", dataTr[2][15:8], 0);
        checkOutput("t3_negZero", dataTr[3][15:8], 8'h80);
        checkOutput("t3_sum00", mSum[0][0], -15);
        checkOutput("t3_sum01", mSum[0][1], 20);
        checkOutput("t3_sum11", mSum[1][1], 0);
        checkOutput("t3_sum22", mSum[2][2], -2);
        checkOutput("t3_sum33", mSum[3][3], -42);
        checkSums("t3", 1);

        $display("[TB] reset during FLUSH");
        fillPattern(2);
        applyStimulus(3, -1, 0, 1'b0, 7);
        rst = 1'b1;
        #1;
        checkOutput("abort_en", en, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_inReady", inReady, 0);
        checkOutput("abort_clrN", arrClrN, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_beats", beats, 0);
        checkOutput("abort_dataOut", dataOut, 0);
        checkOutput("abort_weightOut", weightOut, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fillPattern(5);
        applyStimulus(2, -1, 0, 1'b0, -1);
        checkOutput("t4_enCount", enCount, 8);
        checkOutput("t4_doneCyc", doneCyc, 10);
        checkOutput("t4_beats", beats, 2);
        checkSums("t4", 2);

        $display("[TB] N=1 build");
        n1Vals[0] = 8'h80; n1Vals[1] = 8'h13; n1Vals[2] = 8'h9F;
        s1Start = 1'b1;
        @(posedge clk); #1;
        s1Start = 1'b0;
        n1k = 0; n1En = 0; n1Done = -1; n1Data0 = '0; n1Weight0 = '0;
        for (int c = 0; c < 12; c++) begin
            if (s1En) n1En++;
            if (s1Done && n1Done < 0) n1Done = c;
            if (c == 2) begin
                n1Data0   = s1DataOut;
                n1Weight0 = s1WeightOut;
            end
            if (s1Ready && n1k < 3) begin
                s1Valid  = 1'b1;
                s1Data   = n1Vals[n1k];
                s1Weight = ~n1Vals[n1k];
                s1Last   = (n1k == 2);
                n1k++;
            end else begin
                s1Valid = 1'b0;
                s1Last  = 1'b0;
            end
            @(posedge clk); #1;
        end
        checkOutput("n1_enCount", n1En, 3);
        checkOutput("n1_doneCyc", n1Done, 5);
        checkOutput("n1_beats", s1Beats, 3);
        checkOutput("n1_data0", n1Data0, 8'h80);
        checkOutput("n1_weight0", n1Weight0, 8'h7F);
        checkOutput("n1_busyAfter", s1Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side companion to the sign-magnitude MAC PE array.
- Accepts one k-slice per beat over a valid/ready stream: N activations, one per array row, and N weights, one per array column.
- Emits diagonally skewed data_out/weight_out streams plus a common en to the left and top edges of an NxN output-stationary array.
- Sequences tile start, array clear, feed, pipeline flush and done.

Parameters:
- N, 4, array dimension (rows = columns); legal range 1..16.
- DW, 8, element width; sign-magnitude: bit DW-1 is the sign, the rest is the magnitude.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a tile; sampled only in IDLE.
- in_valid  in  1  slice valid.
- in_ready  out  1  slice accepted when in_valid && in_ready.
- in_data  in  N*DW  activations; row i at bits [i*DW +: DW].
- in_weight  in  N*DW  weights; column j at bits [j*DW +: DW].
- in_last  in  1  marks the final slice of the tile.
- data_out  out  N*DW  row i feed to PE(i,0).
- weight_out  out  N*DW  column j feed to PE(0,j).
- en  out  1  array enable.
- arr_clr_n  out  1  active-low accumulator clear to the array.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when every sum in the array is final.
- beats  out  16  slices accepted in the current tile; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All skew registers, data_out, weight_out, en, done, beats are 0.
  - arr_clr_n=1, in_ready=0.
- FSM states: IDLE, CLR, FEED, FLUSH, DONE.
- IDLE:
  - start=1 -> CLR; beats is zeroed on the same edge.
  - start is ignored in every other state.
- CLR:
  - Lasts exactly one cycle; arr_clr_n is registered and low for exactly this cycle.
  - Then -> FEED.
- FEED:
  - in_ready=1 (combinational from state).
  - A beat is accepted when in_valid && in_ready; beats increments (saturating).
  - An accepted beat with in_last=1 -> FLUSH (or -> DONE if N=1).
- FLUSH:
  - Runs exactly 2N-2 advance cycles, counted by an internal counter.
  - The skew inputs are driven with all-zero elements (a magnitude-0 product leaves sums unchanged).
  - Then -> DONE.
- DONE:
  - done=1 for one cycle, then -> IDLE.
- Advance:
  - advance = (FEED && in_valid) || FLUSH.
  - All skew registers shift only on advance. A stall (in_valid=0 in FEED) freezes every stage; no bubbles are inserted.
- Skew:
  - Row i passes through i+1 registers; column j passes through j+1 registers.
  - Element row 0 / column 0 of a beat accepted at edge t appears at the outputs after edge t.
  - Row i appears after i further advances.
- en:
  - Registered: en(t+1) = advance(t). It is therefore aligned with the updated data_out/weight_out.
  - en=0 in IDLE, CLR, DONE and during stalls.
- No beat is accepted outside FEED. in_last on the very first beat is legal (K=1).
- rst asserted mid-tile: immediate IDLE, all outputs return to reset values, and the partial tile is discarded. The downstream array must be cleared by the next tile's CLR.
- Elements are passed through unmodified; 8'h80 (negative zero) is legal and forwarded as-is.

Test Plan:
- Reset + idle: rst pulse, no start -> en=0, in_ready=0, busy=0, arr_clr_n=1, data_out=0 for 20 cycles.
- Single tile, N=4, K=3, in_valid held high:
  - start -> arr_clr_n low for exactly 1 cycle, then in_ready=1.
  - Row 3 first element appears 3 cycles after row 0.
  - en high for 3+6=9 consecutive cycles; done 1 cycle after the last en; beats=3.
- Golden compare, N=4:
  - Drive an 4xK activation/weight set with mixed signs, e.g. 8'h85 (-5) x 8'h03 (+3) = -15, through a model array of PEs.
  - All 16 sums must equal the reference matmul at done.
- Stall: deassert in_valid for 5 cycles mid-tile -> en=0 and data_out/weight_out frozen for 5 cycles; final sums unchanged vs. no-stall run.
- Boundary:
  - K=1 (in_last on the first beat) -> FLUSH of 6 cycles.
  - N=1 build: FEED->DONE directly, en high for exactly K cycles.
  - start during FEED is ignored.
- Reset mid-FLUSH -> all outputs at reset values on the next sample; a following tile completes correctly with a fresh clear.
